// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared widths, counts and types for the MIPS general-purpose register file
// and its write-decode helper. Import with: import regfile_pkg::*;
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int REG_NUM    = 32;

   // Index of the hardwired-zero register $0
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/demux_dec5x32.sv
// ---------------------------------------------------------------------------
// demux_dec5x32
// 5-to-32 one-hot decoder with enable. Produces one write-enable bit per
// register of the register file.
//
// Ports:
//   en      in   1   decode enable; all outputs 0 when low
//   sel     in   5   selected output index
//   onehot  out  32  en ? (1 << sel) : 0
// ---------------------------------------------------------------------------
module demux_dec5x32
   import regfile_pkg::*;
(
   input  logic             en,
   input  reg_addr_t        sel,
   output logic [REG_NUM-1:0] onehot
);

   // Ternary on en keeps an unknown enable from spreading X beyond the
   // selected bit in simulation: only the bit where both arms differ goes X.
   always_comb begin
      onehot = en ? (REG_NUM'(1) << sel) : '0;
   end

endmodule

// File: rtl/regfile_wdemux32.sv
// ---------------------------------------------------------------------------
// regfile_wdemux32
// MIPS general-purpose register file, 32 x 32-bit. One synchronous write port
// steered through a one-hot write demultiplexer, two combinational read ports.
// Register $0 is never written and always reads as zero.
//
// Ports:
//   clk     in   1   system clock, rising-edge active
//   rst_n   in   1   asynchronous active-low reset, clears all registers
//   we      in   1   write enable
//   waddr   in   5   write register index
//   wdata   in   32  write data
//   raddr1  in   5   read port 1 index (rs)
//   raddr2  in   5   read port 2 index (rt)
//   rdata1  out  32  read port 1 data
//   rdata2  out  32  read port 2 data
//
// Build option:
//   REGFILE_WRITE_BYPASS_EN  when defined, a read of the register being
//                            written in the same cycle returns wdata
//                            (write-through forwarding). Default: reads
//                            return stored contents only.
// ---------------------------------------------------------------------------
module regfile_wdemux32
   import regfile_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);

   logic [REG_NUM-1:0] dec_onehot;
   logic [REG_NUM-1:0] wen;
   logic [DATA_W-1:0]  regs_q [REG_NUM];
   logic [DATA_W-1:0]  regs_d [REG_NUM];

   // One-hot decode of the write index into per-register enables
   demux_dec5x32 u_dec (
      .en     (we),
      .sel    (waddr),
      .onehot (dec_onehot)
   );

   // $0 is hardwired to zero, so its enable is masked off here rather than
   // relying on the read-side zero forcing alone.
   always_comb begin
      wen    = dec_onehot;
      wen[0] = 1'b0;
   end

   // Next-state for every register: hold unless its own enable is set.
   // An unknown enable evaluates false in the if, so registers whose
   // enable bit is X keep their value in simulation.
   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i < REG_NUM; i++) begin
         if (wen[i]) begin
            regs_d[i] = wdata;
         end
      end
   end

   // Storage. Reset clears every register immediately, aborting any write
   // that was in flight when rst_n fell.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read ports. Index 0 always reads zero. With forwarding enabled the
   // in-flight write data is returned for a matching index; forwarding is
   // suppressed while in reset so reads stay zero there.
   always_comb begin
      rdata1 = (raddr1 == REG_ZERO) ? '0 : regs_q[raddr1];
      rdata2 = (raddr2 == REG_ZERO) ? '0 : regs_q[raddr2];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (rst_n && we && (waddr != REG_ZERO) && (raddr1 == waddr)) begin
         rdata1 = wdata;
      end
      if (rst_n && we && (waddr != REG_ZERO) && (raddr2 == waddr)) begin
         rdata2 = wdata;
      end
`else
`endif
   end

endmodule

// File: doc/regfile_wdemux32.md
Name: regfile_wdemux32

Overview:
MIPS general-purpose register file, 32 x 32-bit, for the pc/if/id/rtype datapath. One synchronous write port steers write data into exactly one register through a one-hot write demultiplexer. Two combinational read ports select register contents. It is the write/store side of the operand-select path, and it feeds the ID-stage operand muxes and the R-type ALU.

Parameters:
DATA_W, 32, register and data width in bits
ADDR_W, 5, register address width; register count = 2**ADDR_W = 32

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  reset, asynchronous, active-low; clears all registers
we  input  1  write enable, sampled on rising clk
waddr  input  5  write register index
wdata  input  32  write data
raddr1  input  5  read port 1 index (rs)
raddr2  input  5  read port 2 index (rt)
rdata1  output  32  read port 1 data
rdata2  output  32  read port 2 data

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset: while rst_n=0, all 32 registers are 32'h0000_0000 immediately, with no clock edge needed.
  - rdata1/rdata2 therefore read 0 during reset.
  - Reset deassertion is synchronised externally; the block adds no reset synchroniser.
- Write: on a rising clk with rst_n=1 and we=1, reg[waddr] <= wdata.
  - Exactly one register is enabled, via the one-hot demux decode of waddr.
  - All other registers hold.
  - we=0: no register changes.
- Register $0:
  - Writes with waddr=0 are discarded; the decode output bit 0 is forced to 0.
  - Any read of index 0 returns 0 regardless of storage.
- Read: combinational.
  - rdata1 = reg[raddr1] and rdata2 = reg[raddr2], with zero-cycle latency from address change.
  - Without bypass, a write is visible to reads in the cycle after the write edge.
- Simultaneous events:
  - raddr1 == raddr2 is legal; both ports return the same value.
  - A read and a write to the same index in one cycle return the old value, unless WRITE_BYPASS_EN is defined.
- Reset mid-operation: rst_n falling while we=1 aborts the write. Registers are 0 and stay 0 until rst_n=1 and the next enabled edge.
- X-handling: we=X or waddr=X must not corrupt registers other than the addressed one in simulation. The bench flags X on we as an error.

Optional Feature:
Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: when we=1, waddr!=0 and raddrN==waddr, rdataN = wdata in the same cycle (write-through forwarding for a WB/ID same-cycle hazard). Reads of index 0 remain 0.
- Undefined: reads always return stored contents, with one-cycle write-to-read visibility.

Decomposition:
- Shared package regfile_pkg holds:
  - localparams REG_ADDR_W=5, REG_DATA_W=32, REG_NUM=32, REG_ZERO=5'd0
  - typedef reg_addr_t (logic [4:0])
  - typedef reg_data_t (logic [31:0])
- One natural sub-module: demux_dec5x32.
  - Inputs: en, sel[4:0].
  - Output: one-hot onehot[31:0] = en ? (1<<sel) : 0.
  - It generates the per-register write enables. The top masks bit 0.

Test Plan:
- Reset: hold rst_n=0, assert we=1 waddr=5 wdata=32'hDEADBEEF across edges -> rdata1 (raddr1=5) stays 0. Release rst_n -> still 0 until the next write edge.
- Write/read: we=1 waddr=7 wdata=32'h1234_5678, one edge, then raddr1=7 raddr2=7 -> both ports read 32'h1234_5678. All other registers read 0.
- $0 protection: we=1 waddr=0 wdata=32'hFFFF_FFFF, edge -> raddr1=0 reads 0. Registers 1..31 unchanged.
- Hold: write reg 3 = 32'hA5A5_A5A5, then we=0 with waddr=3 wdata=0 for 4 edges -> reg 3 still reads 32'hA5A5_A5A5.
- Same-cycle RAW: reg 9 = 32'h1, then we=1 waddr=9 wdata=32'h2 with raddr2=9 before the edge -> rdata2 = 32'h1 without the macro, 32'h2 with REGFILE_WRITE_BYPASS_EN. After the edge it reads 32'h2 in both builds.
- Async reset mid-run: fill regs 1..31 with their index, pulse rst_n low between clk edges -> all reads 0 immediately, without waiting for a clk edge.
